dac_sample_sequencer: RTL and testbench

- Upstream feeder for the PMOD DAC SPI driver.
- Buffers SoC-written samples in a small FIFO and paces them out at a programmable sample rate.
- For each sample, drives the driver's din/load_din/start handshake, then waits a fixed transfer window before issuing the next sample.
- Reports underrun and late-tick conditions to the SoC.

---
 rtl/dac_sample_sequencer.sv | 174 +++++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: upstream feeder for the PMOD DAC SPI driver.
// Samples written by the SoC are queued in a small FIFO and released one per
// rate tick. Each release drives the driver's load/start handshake and then
// holds off for a fixed transfer window. Underrun and late ticks are reported
// as sticky flags.
// Optional build macro DAC_SEQ_HOLD_LAST_EN: an empty-FIFO tick re-sends the
// current dac_din (LOAD/START/WAIT) in addition to flagging underrun.
module dac_sample_sequencer #(
    parameter int RESOLUTION  = 16,
    parameter int DEPTH       = 16,
    parameter int XFER_CYCLES = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [15:0]              rate_div,
    input  logic [RESOLUTION-1:0]    wr_data,
    input  logic                     wr_en,
    input  logic                     clr_flags,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic                     late,
    output logic                     busy,
    output logic [RESOLUTION-1:0]    dac_din,
    output logic                     dac_load_din,
    output logic                     dac_start
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             rate_cnt_reg, rate_cnt_next;
    logic                    tick;
    logic [RESOLUTION-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]           level_reg;
    logic [WW-1:0]           wait_reg, wait_next;
    logic [RESOLUTION-1:0]   din_reg;
    logic                    underrun_reg, underrun_next;
    logic                    late_reg, late_next;
    logic                    do_write, do_pop;
    logic                    load_strobe, start_strobe;

    assign full     = (level_reg == LW'(DEPTH));
    assign empty    = (level_reg == '0);
    assign do_write = wr_en && !full;

    // Rate counter: free-runs while enabled and ticks on equality with rate_div.
    // Equality (not >=) means a counter already past a lowered rate_div wraps
    // through 0xFFFF before the next tick.
    always_comb begin
        tick          = 1'b0;
        rate_cnt_next = rate_cnt_reg;
        if (!enable) begin
            rate_cnt_next = '0;
        end else if (rate_cnt_reg == rate_div) begin
            tick          = 1'b1;
            rate_cnt_next = '0;
        end else begin
            rate_cnt_next = rate_cnt_reg + 16'd1;
        end
    end

    // Sample storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_write, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sequencer next state, strobes and sticky flags (a set beats clr_flags).
    always_comb begin
        state_next    = state_reg;
        wait_next     = wait_reg;
        do_pop        = 1'b0;
        load_strobe   = 1'b0;
        start_strobe  = 1'b0;
        underrun_next = clr_flags ? 1'b0 : underrun_reg;
        late_next     = clr_flags ? 1'b0 : late_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    if (!empty) begin
                        do_pop     = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        underrun_next = 1'b1;
`ifdef DAC_SEQ_HOLD_LAST_EN
                        state_next    = ST_LOAD;
`endif
                    end
                end
            end
            ST_LOAD: begin
                load_strobe = 1'b1;
                state_next  = ST_START;
            end
            ST_START: begin
                start_strobe = 1'b1;
                wait_next    = WW'(XFER_CYCLES - 1);
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (tick && (state_reg != ST_IDLE)) begin
            late_next = 1'b1;
        end
    end

    // Sequencer state, counters, flags and the registered sample read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rate_cnt_reg <= '0;
            wait_reg     <= '0;
            din_reg      <= '0;
            underrun_reg <= 1'b0;
            late_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rate_cnt_reg <= rate_cnt_next;
            wait_reg     <= wait_next;
            underrun_reg <= underrun_next;
            late_reg     <= late_next;
            if (do_pop) begin
                din_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign level        = level_reg;
    assign underrun     = underrun_reg;
    assign late         = late_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign dac_din      = din_reg;
    assign dac_load_din = load_strobe;
    assign dac_start    = start_strobe;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench for dac_sample_sequencer: a vector table for the FIFO/flag
// basics plus hand-written sequences for pacing, wrap, late and reset cases.
module tb_dac_sample_sequencer;

    localparam int RES   = 16;
    localparam int DEPTH = 16;
    localparam int XFER  = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] rate_div = '0;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        clr_flags = 1'b0;
    logic        full, empty, underrun, late, busy, dac_load_din, dac_start;
    logic [4:0]  level;
    logic [15:0] dac_din;

    dac_sample_sequencer #(.RESOLUTION(RES), .DEPTH(DEPTH), .XFER_CYCLES(XFER)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
        .wr_data(wr_data), .wr_en(wr_en), .clr_flags(clr_flags),
        .full(full), .empty(empty), .level(level), .underrun(underrun),
        .late(late), .busy(busy), .dac_din(dac_din),
        .dac_load_din(dac_load_din), .dac_start(dac_start)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int          load_cyc_q[$];
    logic [15:0] load_din_q[$];
    int          start_cyc_q[$];

    typedef struct {
        logic        en;
        logic [15:0] rd;
        logic        wr;
        logic [15:0] wd;
        logic        clr;
        logic [4:0]  lvl;
        logic        full;
        logic        empty;
        logic        und;
        logic        late;
        logic        busy;
        logic        load;
        logic        start;
        logic [15:0] din;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    // One clock: sample just after the edge and log any strobes.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (dac_load_din) begin
            load_cyc_q.push_back(cyc);
            load_din_q.push_back(dac_din);
        end
        if (dac_start) start_cyc_q.push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_q();
        load_cyc_q.delete();
        load_din_q.delete();
        start_cyc_q.delete();
    endtask

    task automatic write(input logic [15:0] d);
        wr_en = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic apply_reset();
        enable = 1'b0; wr_en = 1'b0; clr_flags = 1'b0;
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_idle: busy still 1 after 200 cycles, required 0");
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        //       en  rd     wr  wd        clr  lvl full empty und late busy load start din
        vt[0] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[1] = '{1'b0, 16'd0, 1'b1, 16'hAAAA, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[2] = '{1'b0, 16'd0, 1'b1, 16'hBBBB, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vt[3] = '{1'b1, 16'd0, 1'b1, 16'hCCCC, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA};
        vt[4] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hAAAA};
        vt[5] = '{1'b1, 16'd0, 1'b0, 16'h0000, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA};
        vt[6] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAAAA};
        vt[7] = '{1'b1, 16'd0, 1'b0, 16'h0000, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA};
        vt[8] = '{1'b0, 16'd0, 1'b1, 16'hDDDD, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA};

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #2;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_din", 32'(dac_din), 32'd0);
        check("rst_flags", 32'({underrun, late, dac_load_din, dac_start}), 32'd0);
        run(2);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            enable = vt[i].en; rate_div = vt[i].rd; wr_en = vt[i].wr;
            wr_data = vt[i].wd; clr_flags = vt[i].clr;
            step();
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].lvl));
            check($sformatf("vec%0d_full_empty", i), 32'({full, empty}), 32'({vt[i].full, vt[i].empty}));
            check($sformatf("vec%0d_flags", i), 32'({underrun, late}), 32'({vt[i].und, vt[i].late}));
            check($sformatf("vec%0d_strobes", i), 32'({busy, dac_load_din, dac_start}),
                  32'({vt[i].busy, vt[i].load, vt[i].start}));
            check($sformatf("vec%0d_din", i), 32'(dac_din), 32'(vt[i].din));
        end
        enable = 1'b0; wr_en = 1'b0; clr_flags = 1'b0;

        // Reset mid-WAIT: everything clears without waiting for a clock.
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_din", 32'(dac_din), 32'd0);
        check("midrst_flags", 32'({underrun, late}), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        clear_q();
        run(3);
        check("midrst_no_strobes", 32'(load_cyc_q.size() + start_cyc_q.size()), 32'd0);
        rst_n = 1'b1;
        write(16'h5555);
        rate_div = 16'd0;
        enable = 1'b1;
        c0 = cyc;
        run(2);
        enable = 1'b0;
        check("restart_nloads", 32'(load_cyc_q.size()), 32'd1);
        check("restart_nstarts", 32'(start_cyc_q.size()), 32'd1);
        if (load_cyc_q.size() >= 1) begin
            check("restart_load_cyc", 32'(load_cyc_q[0] - c0), 32'd1);
            check("restart_load_din", 32'(load_din_q[0]), 32'h5555);
        end
        if (start_cyc_q.size() >= 1) check("restart_start_cyc", 32'(start_cyc_q[0] - c0), 32'd2);
        wait_idle();

        // Pacing at rate_div=99, then underrun on the third tick.
        apply_reset();
        write(16'h1234);
        write(16'hABCD);
        clear_q();
        rate_div = 16'd99;
        enable = 1'b1;
        c0 = cyc;
        run(299);
        check("pace_underrun_before", 32'(underrun), 32'd0);
        check("pace_empty", 32'(empty), 32'd1);
        step();
        check("pace_underrun_third_tick", 32'(underrun), 32'd1);
        run(10);
        enable = 1'b0;
`ifdef DAC_SEQ_HOLD_LAST_EN
        check("pace_nloads", 32'(load_cyc_q.size()), 32'd3);
        if (load_cyc_q.size() >= 3) begin
            check("hold_load_cyc", 32'(load_cyc_q[2] - c0), 32'd300);
            check("hold_load_din", 32'(load_din_q[2]), 32'hABCD);
        end
`else
        check("pace_nloads", 32'(load_cyc_q.size()), 32'd2);
        check("pace_nstarts", 32'(start_cyc_q.size()), 32'd2);
`endif
        if (load_cyc_q.size() >= 2 && start_cyc_q.size() >= 2) begin
            check("pace_load0_cyc", 32'(load_cyc_q[0] - c0), 32'd100);
            check("pace_load0_din", 32'(load_din_q[0]), 32'h1234);
            check("pace_start0_cyc", 32'(start_cyc_q[0] - c0), 32'd101);
            check("pace_load1_cyc", 32'(load_cyc_q[1] - c0), 32'd200);
            check("pace_load1_din", 32'(load_din_q[1]), 32'hABCD);
            check("pace_start1_cyc", 32'(start_cyc_q[1] - c0), 32'd201);
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("clr_underrun", 32'(underrun), 32'd0);
        wait_idle();

        // Fill past full across pointer wrap, then drain at rate_div=0.
        for (int i = 0; i < DEPTH + 1; i++) begin
            write(16'h0100 + 16'(i));
            if (i == DEPTH - 1) check("fill_full_at_depth", 32'({full, level}), 32'({1'b1, 5'd16}));
        end
        check("fill_overflow_dropped", 32'({full, level}), 32'({1'b1, 5'd16}));
        clear_q();
        rate_div = 16'd0;
        enable = 1'b1;
        c0 = cyc;
        run(340);
        enable = 1'b0;
        check("drain_count_ge16", 32'(load_cyc_q.size() >= 16 && start_cyc_q.size() >= 16), 32'd1);
        if (load_cyc_q.size() >= 16 && start_cyc_q.size() >= 16) begin
            check("drain_first_load_cyc", 32'(load_cyc_q[0] - c0), 32'd1);
            for (int i = 0; i < 16; i++)
                check($sformatf("drain_din%0d", i), 32'(load_din_q[i]), 32'h0100 + 32'(i));
            for (int i = 0; i < 15; i++)
                check($sformatf("drain_gap%0d", i), 32'(start_cyc_q[i+1] - start_cyc_q[i]), 32'(XFER + 3));
        end
        check("drain_late", 32'(late), 32'd1);
        check("drain_empty", 32'(empty), 32'd1);
        wait_idle();

        // rate_div=5 is shorter than a transfer: ticks get dropped as late.
        apply_reset();
        for (int i = 0; i < 4; i++) write(16'h0A00 + 16'(i));
        clear_q();
        rate_div = 16'd5;
        enable = 1'b1;
        c0 = cyc;
        run(100);
        enable = 1'b0;
        check("fast_late", 32'(late), 32'd1);
        check("fast_count_ge4", 32'(load_cyc_q.size() >= 4 && start_cyc_q.size() >= 4), 32'd1);
        if (load_cyc_q.size() >= 4 && start_cyc_q.size() >= 4) begin
            check("fast_first_load_cyc", 32'(load_cyc_q[0] - c0), 32'd6);
            for (int i = 0; i < 4; i++)
                check($sformatf("fast_din%0d", i), 32'(load_din_q[i]), 32'h0A00 + 32'(i));
            for (int i = 0; i < 3; i++)
                check($sformatf("fast_gap%0d", i), 32'(start_cyc_q[i+1] - start_cyc_q[i]), 32'd24);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
